// File: rtl/evm_top_module_if.sv
// Voting-machine front panel bundle: booth controls, IDs and buttons in, LED/tallies/winner out.
// Pure wiring, no latency and no backpressure; master drives the panel, slave is the EVM core.
interface evm_top_module_if;
    logic       control;
    logic       mode;
    logic       system_reset;
    logic       read_enable;
    logic       push1;
    logic       push2;
    logic       push3;
    logic       push4;
    logic       show_result;
    logic [4:0] voter_id;
    logic [4:0] reset_id;
    logic [4:0] officer_id;
    logic       status_led;
    logic [1:0] winner;
    logic [7:0] total_voting;
    logic [5:0] vote_party1;
    logic [5:0] vote_party2;
    logic [5:0] vote_party3;
    logic [5:0] vote_party4;

    modport master (
        output control, mode, system_reset, read_enable,
        output push1, push2, push3, push4, show_result,
        output voter_id, reset_id, officer_id,
        input  status_led, winner, total_voting,
        input  vote_party1, vote_party2, vote_party3, vote_party4
    );

    modport slave (
        input  control, mode, system_reset, read_enable,
        input  push1, push2, push3, push4, show_result,
        input  voter_id, reset_id, officer_id,
        output status_led, winner, total_voting,
        output vote_party1, vote_party2, vote_party3, vote_party4
    );
endinterface

// File: rtl/evm_top_module.sv
// 4-party electronic voting machine: officer-opened session, one vote per voter ID, result display.
// Counts update 1 clk after the qualifying edge, winner 1 clk later; no backpressure (level inputs).
module evm_top_module #(
    parameter logic [4:0] OFFICER_ID = 5'b11111,
    parameter logic [5:0] MAX_PARTY  = 6'd63
) (
    input  logic             clk,
    input  logic             reset,
    evm_top_module_if.slave  bus
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_SESSION = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [3:0][5:0] tally_q, tally_d;
    logic [7:0]      total_q, total_d;
    logic [30:0]     voted_q, voted_d;
    logic [4:0]      voter_id_q, voter_id_d;
    logic            led_q, led_d;
    logic [1:0]      winner_q, winner_d;

    logic        voting_mode;
    logic        sys_clear;
    logic [3:0]  pressed;
    logic        single_press;
    logic [1:0]  party;
    logic [31:0] voted_ext;
    logic [31:0] voted_ext_set;
    logic        accept;
    logic        display;

    function automatic logic [1:0] argmax(input logic [3:0][5:0] t);
        logic [1:0] best;
        best = 2'd0;
        // Strict compare keeps the lowest index on ties
        for (int i = 1; i < 4; i++) begin
            if (t[i] > t[best]) begin
                best = 2'(i);
            end
        end
        return best;
    endfunction

    assign voting_mode = bus.mode & bus.control;
    assign sys_clear   = bus.system_reset && (bus.reset_id == OFFICER_ID);
    assign display     = !bus.mode && !bus.control && bus.show_result;

    // Floating or unknown buttons must not register as presses
    assign pressed = {bus.push4 === 1'b1, bus.push3 === 1'b1,
                      bus.push2 === 1'b1, bus.push1 === 1'b1};

    always_comb begin
        single_press = 1'b1;
        party        = 2'd0;
        case (pressed)
            4'b0001: party = 2'd0;
            4'b0010: party = 2'd1;
            4'b0100: party = 2'd2;
            4'b1000: party = 2'd3;
            default: single_press = 1'b0;
        endcase
    end

    // Bit 0 of the extended map stands for the invalid ID 0 and is never set
    assign voted_ext     = {voted_q, 1'b0};
    assign voted_ext_set = voted_ext | (32'd1 << bus.voter_id);

    assign accept = (state_q == S_SESSION) && voting_mode
                 && (bus.voter_id == voter_id_q) && (bus.voter_id != 5'd0)
                 && !voted_ext[bus.voter_id] && single_press;

    always_comb begin
        state_d = state_q;
        if (!voting_mode) begin
            state_d = S_IDLE;
        end else if (bus.officer_id == OFFICER_ID) begin
            state_d = S_SESSION;
        end
    end

    always_comb begin
        tally_d    = tally_q;
        total_d    = total_q;
        voted_d    = voted_q;
        led_d      = 1'b0;
        voter_id_d = bus.voter_id;
        winner_d   = argmax(tally_q);
        if (sys_clear) begin
            tally_d    = '0;
            total_d    = 8'd0;
            voted_d    = 31'd0;
            voter_id_d = 5'd0;
            winner_d   = 2'd0;
        end else if (accept) begin
            if (tally_q[party] != MAX_PARTY) begin
                tally_d[party] = tally_q[party] + 6'd1;
            end
            if (total_q != 8'hFF) begin
                total_d = total_q + 8'd1;
            end
            voted_d = voted_ext_set[31:1];
            led_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tally_q    <= '0;
            total_q    <= 8'd0;
            voted_q    <= 31'd0;
            voter_id_q <= 5'd0;
            led_q      <= 1'b0;
            winner_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            tally_q    <= tally_d;
            total_q    <= total_d;
            voted_q    <= voted_d;
            voter_id_q <= voter_id_d;
            led_q      <= led_d;
            winner_q   <= winner_d;
        end
    end

    assign bus.status_led   = led_q;
    assign bus.total_voting = total_q;
    assign bus.winner       = display ? winner_q : 2'd0;
    assign bus.vote_party1  = (display && bus.read_enable) ? tally_q[0] : 6'd0;
    assign bus.vote_party2  = (display && bus.read_enable) ? tally_q[1] : 6'd0;
    assign bus.vote_party3  = (display && bus.read_enable) ? tally_q[2] : 6'd0;
    assign bus.vote_party4  = (display && bus.read_enable) ? tally_q[3] : 6'd0;

endmodule

// File: tb/tb_evm_top_module.sv
// Directed bench for evm_top_module: accepted votes queue their expected total,
// a monitor pops one entry per status_led pulse; display values are checked against hand constants.
module tb_evm_top_module;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   exp_total;
    int   exp_q[$];

    evm_top_module_if bus ();

    evm_top_module dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic m, input logic c);
        bus.mode    = m;
        bus.control = c;
    endtask

    // Present a voter with a button pattern {p4,p3,p2,p1}; buttons stay as left
    task automatic cast(input logic [4:0] id, input logic [3:0] p, input bit will_accept);
        @(negedge clk);
        bus.voter_id = id;
        {bus.push4, bus.push3, bus.push2, bus.push1} = p;
        if (will_accept) begin
            exp_total++;
            exp_q.push_back(exp_total);
        end
        tick(10);
    endtask

    task automatic chk_display(input string tag, input int p1, input int p2,
                               input int p3, input int p4, input int w);
        #1;
        chk({tag, "_vp1"}, int'(bus.vote_party1), p1);
        chk({tag, "_vp2"}, int'(bus.vote_party2), p2);
        chk({tag, "_vp3"}, int'(bus.vote_party3), p3);
        chk({tag, "_vp4"}, int'(bus.vote_party4), p4);
        chk({tag, "_winner"}, int'(bus.winner), w);
    endtask

    // Scoreboard monitor: one expected total per LED pulse
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset && bus.status_led) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_led actual=1 expected=0 total=%0d", bus.total_voting);
                end else begin
                    chk("led_total", int'(bus.total_voting), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        exp_total = 0;
        reset     = 1'b0;
        set_mode(1'b0, 1'b0);
        bus.system_reset = 1'b0;
        bus.read_enable  = 1'b1;
        bus.show_result  = 1'b1;
        {bus.push4, bus.push3, bus.push2, bus.push1} = 4'b0000;
        bus.voter_id   = 5'd0;
        bus.reset_id   = 5'd0;
        bus.officer_id = 5'd0;

        // Reset
        tick(2);
        #1;
        chk("rst_led", int'(bus.status_led), 0);
        chk("rst_total", int'(bus.total_voting), 0);
        chk_display("rst", 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick(1);

        // Session and eight votes, p1 held from voter 7 to voter 9
        bus.show_result = 1'b0;
        bus.officer_id  = 5'b11111;
        set_mode(1'b1, 1'b1);
        tick(2);
        cast(5'd1, 4'b0001, 1'b1);
        cast(5'd2, 4'b0010, 1'b1);
        cast(5'd3, 4'b0100, 1'b1);
        cast(5'd4, 4'b1000, 1'b1);
        cast(5'd5, 4'b0001, 1'b1);
        cast(5'd6, 4'b1000, 1'b1);
        cast(5'd7, 4'b0001, 1'b1);
        cast(5'd9, 4'b0001, 1'b1);
        #1;
        chk("vote_total", int'(bus.total_voting), 8);
        chk("vote_hidden_vp1", int'(bus.vote_party1), 0);
        set_mode(1'b0, 1'b0);
        bus.show_result = 1'b1;
        chk_display("res1", 4, 1, 1, 2, 0);

        // Duplicate, ID 0 and double press are all ignored
        @(negedge clk);
        bus.show_result = 1'b0;
        set_mode(1'b1, 1'b1);
        tick(2);
        cast(5'd1, 4'b0010, 1'b0);
        cast(5'd0, 4'b0010, 1'b0);
        cast(5'd10, 4'b0011, 1'b0);
        #1;
        chk("reject_total", int'(bus.total_voting), 8);
        {bus.push4, bus.push3, bus.push2, bus.push1} = 4'b0000;

        // Mismatched then authorised system_reset
        @(negedge clk);
        set_mode(1'b0, 1'b0);
        bus.show_result  = 1'b1;
        bus.system_reset = 1'b1;
        bus.reset_id     = 5'b00011;
        tick(1);
        bus.system_reset = 1'b0;
        tick(1);
        #1;
        chk("badsys_total", int'(bus.total_voting), 8);
        chk("badsys_vp1", int'(bus.vote_party1), 4);
        @(negedge clk);
        bus.system_reset = 1'b1;
        bus.reset_id     = 5'b11111;
        tick(1);
        bus.system_reset = 1'b0;
        tick(1);
        #1;
        chk("sys_total", int'(bus.total_voting), 0);
        chk_display("sys", 0, 0, 0, 0, 0);
        exp_total = 0;
        @(negedge clk);
        bus.show_result = 1'b0;
        set_mode(1'b1, 1'b1);
        tick(2);
        cast(5'd1, 4'b0010, 1'b1);
        #1;
        chk("revote_total", int'(bus.total_voting), 1);

        // No session with a wrong officer ID
        {bus.push4, bus.push3, bus.push2, bus.push1} = 4'b0000;
        @(negedge clk);
        set_mode(1'b0, 1'b0);
        tick(2);
        bus.officer_id = 5'b00001;
        set_mode(1'b1, 1'b1);
        tick(2);
        cast(5'd2, 4'b0100, 1'b0);
        #1;
        chk("nosess_total", int'(bus.total_voting), 1);
        {bus.push4, bus.push3, bus.push2, bus.push1} = 4'b0000;
        @(negedge clk);
        bus.officer_id = 5'b11111;
        tick(2);

        // 2-2 tie between parties 2 and 3, voter 31 included
        cast(5'd2, 4'b0100, 1'b1);
        cast(5'd3, 4'b0010, 1'b1);
        cast(5'd31, 4'b0100, 1'b1);
        {bus.push4, bus.push3, bus.push2, bus.push1} = 4'b0000;
        @(negedge clk);
        set_mode(1'b0, 1'b0);
        bus.show_result = 1'b1;
        bus.read_enable = 1'b1;
        chk_display("tie", 0, 2, 2, 0, 1);
        chk("tie_total", int'(bus.total_voting), 4);

        // read_enable low hides tallies but not the total
        @(negedge clk);
        bus.read_enable = 1'b0;
        chk_display("rd0", 0, 0, 0, 0, 1);
        chk("rd0_total", int'(bus.total_voting), 4);
        @(negedge clk);
        bus.show_result = 1'b0;
        #1;
        chk("noshow_winner", int'(bus.winner), 0);

        tick(3);
        chk("pending_leds", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
